// File: rtl/instruction_loader.sv
// instruction_loader
//   Byte-serial program loader driving the write port of the byte-addressed
//   instruction memory. A framed stream (16-bit word count MSB first, then
//   count*4 instruction bytes, big-endian within each word) arrives over a
//   valid/ready handshake. Each byte is written at consecutive addresses from
//   0, and the CPU is held for the duration of the load.
//
//   Optional feature macro: LOADER_CHECKSUM_EN
//     When defined, a trailing checksum byte (XOR of both header bytes and
//     all data bytes) is accepted in a CHK state. A mismatch sets err.
//
//   Ports:
//     clk          system clock, all logic on posedge
//     rst          synchronous active-high reset
//     start        one-cycle pulse, begins a load when idle
//     in_data      stream byte
//     in_valid     in_data is valid
//     in_ready     loader accepts a byte this cycle
//     mem_wr_en    byte write strobe to instruction memory
//     mem_wr_addr  byte write address (zero-extended)
//     mem_wr_data  byte to write
//     cpu_hold     holds the CPU while loading
//     busy         loader is not idle
//     done         one-cycle pulse on successful completion
//     err          sticky error flag, cleared by start or rst
module instruction_loader #(
  parameter int MEM_SIZE = 2048,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [7:0]        mem_wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR_HI = 3'd1,
    ST_HDR_LO = 3'd2,
    ST_DATA   = 3'd3,
`ifdef LOADER_CHECKSUM_EN
    ST_CHK    = 3'd4,
`endif
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  // State entered after the last data byte or a zero word count.
`ifdef LOADER_CHECKSUM_EN
  localparam state_t ST_AFTER_DATA = ST_CHK;
`else
  localparam state_t ST_AFTER_DATA = ST_DONE;
`endif

  // Size limit in the same 19-bit domain as count*4 so the compare cannot overflow.
  localparam logic [18:0] MEM_BYTES = 19'(MEM_SIZE);

  state_t              state_r;
  state_t              state_nx_s;
  logic [15:0]         count_r;
  logic [18:0]         byte_addr_r;
  logic [15:0]         hdr_count_s;
  logic [18:0]         hdr_bytes_s;
  logic [18:0]         last_addr_s;
  logic                accept_s;
  logic                in_ready_r;
  logic                mem_wr_en_r;
  logic [ADDR_W-1:0]   mem_wr_addr_r;
  logic [7:0]          mem_wr_data_r;
  logic                cpu_hold_r;
  logic                busy_r;
  logic                done_r;
  logic                err_r;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          csum_r;
`endif

  // True in states that consume stream bytes; these are also the CPU-hold states.
  function automatic logic is_load_state(input state_t s);
    logic r;
    case (s)
      ST_HDR_HI: r = 1'b1;
      ST_HDR_LO: r = 1'b1;
      ST_DATA:   r = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      ST_CHK:    r = 1'b1;
`endif
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

  // Running checksum step: byte-wise XOR.
  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  assign accept_s    = in_valid & in_ready_r;
  assign hdr_count_s = {count_r[15:8], in_data};
  assign hdr_bytes_s = {1'b0, hdr_count_s, 2'b00};
  // Only used in DATA, where count is at least 1, so no underflow.
  assign last_addr_s = {1'b0, count_r, 2'b00} - 19'd1;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nx_s = ST_HDR_HI;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_HDR_HI: begin
        if (accept_s) begin
          state_nx_s = ST_HDR_LO;
        end else begin
          state_nx_s = ST_HDR_HI;
        end
      end
      ST_HDR_LO: begin
        if (!accept_s) begin
          state_nx_s = ST_HDR_LO;
        end else if (hdr_count_s == 16'd0) begin
          state_nx_s = ST_AFTER_DATA;
        end else if (hdr_bytes_s > MEM_BYTES) begin
          state_nx_s = ST_ERR;
        end else begin
          state_nx_s = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept_s && (byte_addr_r == last_addr_s)) begin
          state_nx_s = ST_AFTER_DATA;
        end else begin
          state_nx_s = ST_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (!accept_s) begin
          state_nx_s = ST_CHK;
        end else if (in_data == csum_r) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_ERR;
        end
      end
`endif
      ST_DONE: state_nx_s = ST_IDLE;
      ST_ERR:  state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Status outputs, registered from the next state so they line up with state_r.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_r <= 1'b0;
      cpu_hold_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      in_ready_r <= is_load_state(state_nx_s);
      cpu_hold_r <= is_load_state(state_nx_s);
      busy_r     <= (state_nx_s != ST_IDLE);
      done_r     <= (state_nx_s == ST_DONE);
      if (state_nx_s == ST_ERR) begin
        err_r <= 1'b1;
      end else if ((state_r == ST_IDLE) && start) begin
        err_r <= 1'b0;
      end else begin
        err_r <= err_r;
      end
    end
  end

  // Header capture, address counter and the one-cycle-latency write register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r       <= 16'd0;
      byte_addr_r   <= 19'd0;
      mem_wr_en_r   <= 1'b0;
      mem_wr_addr_r <= '0;
      mem_wr_data_r <= 8'd0;
    end else begin
      mem_wr_en_r <= accept_s && (state_r == ST_DATA);
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            count_r     <= 16'd0;
            byte_addr_r <= 19'd0;
          end
        end
        ST_HDR_HI: begin
          if (accept_s) begin
            count_r[15:8] <= in_data;
          end
        end
        ST_HDR_LO: begin
          if (accept_s) begin
            count_r[7:0] <= in_data;
            byte_addr_r  <= 19'd0;
          end
        end
        ST_DATA: begin
          if (accept_s) begin
            mem_wr_addr_r <= ADDR_W'(byte_addr_r);
            mem_wr_data_r <= in_data;
            byte_addr_r   <= byte_addr_r + 19'd1;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR over header and data bytes, cleared on start.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum_r <= 8'd0;
    end else if ((state_r == ST_IDLE) && start) begin
      csum_r <= 8'd0;
    end else if (accept_s && ((state_r == ST_HDR_HI) || (state_r == ST_HDR_LO) ||
                              (state_r == ST_DATA))) begin
      csum_r <= csum_step(csum_r, in_data);
    end else begin
      csum_r <= csum_r;
    end
  end
`endif

  assign in_ready    = in_ready_r;
  assign mem_wr_en   = mem_wr_en_r;
  assign mem_wr_addr = mem_wr_addr_r;
  assign mem_wr_data = mem_wr_data_r;
  assign cpu_hold    = cpu_hold_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign err         = err_r;

endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader
//   Directed-vector bench for instruction_loader. Stimulus is driven on the
//   falling edge; DUT outputs are sampled on the falling edge. A monitor logs
//   every write strobe with its cycle number so address order, data and
//   write spacing can be compared against hand-computed expectations.
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_wr_en;
  logic [31:0] mem_wr_addr;
  logic [7:0]  mem_wr_data;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  int          n_checks = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  logic [31:0] wa_q[$];
  logic [7:0]  wd_q[$];
  int          wc_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  run_x = 8'd0;

  always #5 clk = ~clk;

  instruction_loader #(.MEM_SIZE(2048), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // Write and done monitor, one sample per cycle on the falling edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mem_wr_en) begin
      wa_q.push_back(mem_wr_addr);
      wd_q.push_back(mem_wr_data);
      wc_q.push_back(cyc);
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    #1;
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    exp_q.delete();
    done_cnt = 0;
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_x = 8'd0;
  endtask

  // Present one byte and return just after the posedge that accepts it.
  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_val("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    run_x = run_x ^ b;
  endtask

  // Trailing checksum byte, present only when the feature is built in.
  task automatic send_csum();
`ifdef LOADER_CHECKSUM_EN
    send_byte(run_x);
`endif
  endtask

  task automatic idle_valid();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("idle_timeout", 32'(busy), 32'd0);
    #2;
  endtask

  // Compare logged writes against exp_q: addresses 0.., data, spacing.
  task automatic check_writes(input string tag, input int step);
    check_val({tag, "_nwr"}, 32'(wa_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < wa_q.size() && i < exp_q.size(); i++) begin
      check_val($sformatf("%s_addr%0d", tag, i), wa_q[i], 32'(i));
      check_val($sformatf("%s_data%0d", tag, i), 32'(wd_q[i]), 32'(exp_q[i]));
      if (i > 0) check_val($sformatf("%s_gap%0d", tag, i), 32'(wc_q[i] - wc_q[i-1]), 32'(step));
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_in_ready", 32'(in_ready), 32'd0);
    check_val("rst_wr_en", 32'(mem_wr_en), 32'd0);
    check_val("rst_wr_addr", mem_wr_addr, 32'd0);
    check_val("rst_wr_data", 32'(mem_wr_data), 32'd0);
    check_val("rst_hold", 32'(cpu_hold), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    // One word, valid held high
    clear_log();
    start_pulse();
    check_val("t1_busy", 32'(busy), 32'd1);
    check_val("t1_hold", 32'(cpu_hold), 32'd1);
    check_val("t1_ready", 32'(in_ready), 32'd1);
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hE3); send_byte(8'hA0); send_byte(8'h00); send_byte(8'h14);
    send_csum();
    idle_valid();
    wait_idle();
    exp_q = '{8'hE3, 8'hA0, 8'h00, 8'h14};
    check_writes("t1", 1);
    check_val("t1_done_cnt", 32'(done_cnt), 32'd1);
    check_val("t1_hold_end", 32'(cpu_hold), 32'd0);
    check_val("t1_err", 32'(err), 32'd0);

    // Two words, valid toggled every cycle
    clear_log();
    start_pulse();
    send_byte(8'h00); send_byte(8'h02);
    for (int i = 0; i < 8; i++) begin
      send_byte(8'h50 + 8'(i));
      idle_valid();
      if (i < 7) check_val($sformatf("t2_ready_gap%0d", i), 32'(in_ready), 32'd1);
    end
    send_csum();
    idle_valid();
    wait_idle();
    exp_q = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57};
    check_writes("t2", 2);
    check_val("t2_done_cnt", 32'(done_cnt), 32'd1);

    // Oversize count 513 -> error, no writes, sticky err
    clear_log();
    start_pulse();
    send_byte(8'h02); send_byte(8'h01);
    idle_valid();
    check_val("t3_err_now", 32'(err), 32'd1);
    check_val("t3_hold_now", 32'(cpu_hold), 32'd0);
    check_val("t3_busy_now", 32'(busy), 32'd1);
    repeat (4) @(negedge clk);
    check_val("t3_err_sticky", 32'(err), 32'd1);
    check_val("t3_busy_end", 32'(busy), 32'd0);
    check_val("t3_nwr", 32'(wa_q.size()), 32'd0);
    check_val("t3_done_cnt", 32'(done_cnt), 32'd0);
    start_pulse();
    check_val("t3_err_clr", 32'(err), 32'd0);

    // Zero count: done one cycle after the last header byte
    send_byte(8'h00); send_byte(8'h00);
    send_csum();
    idle_valid();
    check_val("t5_zero_done", 32'(done), 32'd1);
    check_val("t5_zero_hold", 32'(cpu_hold), 32'd0);
    @(negedge clk);
    check_val("t5_zero_done_off", 32'(done), 32'd0);
    check_val("t5_zero_busy", 32'(busy), 32'd0);

    // Reset after three data bytes, then a clean reload
    clear_log();
    start_pulse();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h91); send_byte(8'h92); send_byte(8'h93);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("t4_busy", 32'(busy), 32'd0);
    check_val("t4_hold", 32'(cpu_hold), 32'd0);
    check_val("t4_wr_en", 32'(mem_wr_en), 32'd0);
    check_val("t4_ready", 32'(in_ready), 32'd0);
    #1;
    exp_q = '{8'h91, 8'h92, 8'h93};
    check_writes("t4a", 1);
    clear_log();
    start_pulse();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
    send_csum();
    idle_valid();
    wait_idle();
    exp_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    check_writes("t4b", 1);
    check_val("t4b_done_cnt", 32'(done_cnt), 32'd1);

    // start during DATA is ignored
    clear_log();
    start_pulse();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22);
    start = 1'b1;
    send_byte(8'h33);
    start = 1'b0;
    send_byte(8'h44);
    send_csum();
    idle_valid();
    wait_idle();
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    check_writes("t5", 1);
    check_val("t5_done_cnt", 32'(done_cnt), 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // Wrong checksum 44 (expected 45) -> err, then retry with 45
    clear_log();
    start_pulse();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h44);
    idle_valid();
    check_val("t6_bad_err", 32'(err), 32'd1);
    check_val("t6_bad_done", 32'(done), 32'd0);
    wait_idle();
    start_pulse();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h45);
    idle_valid();
    check_val("t6_ok_done", 32'(done), 32'd1);
    check_val("t6_ok_err", 32'(err), 32'd0);
    wait_idle();
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
